interrupt_factor_ctrl: RTL
==========================

# interrupt_factor_ctrl

Peripheral-side interrupt controller for the CPU core's 15-line `interrupt_req` input. It latches rising edges from 15 peripheral interrupt sources into factor flags and holds a per-line mask register. It drives `interrupt_req = factor & mask` to the core. Factor and mask nibbles are exposed on the 4-bit I/O bus, and reading a factor nibble clears it, matching the E0C6S46 factor-register semantics. It sits between the timers/keys/serial blocks and the CPU core.

## Interface
- `NUM_SOURCES`, 15: number of interrupt lines. Fixed to 15 for the core. Line i maps to nibble i/4, bit i%4; bit 15 is unimplemented.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `source`  in  15  peripheral interrupt pulses, synchronous to `clk`; a rising edge is an event.
- `bus_addr`  in  4  register select.
- `bus_write_en`  in  1  write strobe, one cycle.
- `bus_read_en`  in  1  read strobe, one cycle.
- `bus_data_in`  in  4  write data.
- `bus_data_out`  out  4  registered read data.
- `interrupt_req`  out  15  `factor & mask` to the CPU core.
- `pending_valid`  out  1  any bit of `interrupt_req` set.
- `pending_index`  out  4  index of the lowest set `interrupt_req` bit; 0 when none is set.

## Operation
- Register map:
  - 0x0–0x3: factor nibbles 0–3. Read-clear; writes are ignored.
  - 0x4–0x7: mask nibbles 0–3. Read/write.
  - 0x8: `{pending_valid ? pending_index : 4'h0}`, read-only.
  - 0x9–0xF: read 0; writes are ignored.
- Bit 3 of nibble 3 (line 15) always reads 0 and cannot be written.
- Edge detect:
  - `source_prev` register, reset 0.
  - An event on line i occurs when `source[i] & ~source_prev[i]`.
  - A level held high produces exactly one event.
- Factor flags:
  - Set on an event regardless of mask.
  - Cleared only by a read of the containing factor nibble, or by reset.
- Read-clear:
  - On `bus_read_en` at address 0x0–0x3, `bus_data_out` captures the current nibble.
  - All four bits of that nibble clear on the same edge.
- Set vs clear:
  - If an event on a line coincides with a read-clear of its nibble, set wins and the flag stays 1.
  - The read data shows the pre-edge value.
- Mask writes:
  - `bus_write_en` at 0x4–0x7 loads `bus_data_in` on the edge.
  - A masked factor stays latched; unmasking later asserts the request with no new event needed.
- Simultaneous read and write strobes: the write takes effect, and read data for that cycle is the pre-edge value.
- `interrupt_req` is combinational from the registered `factor` and `mask`. It has no other state, so it drops as soon as the factor is cleared.
- Priority encoder is combinational: line 0 is highest priority, line 14 lowest.

## Timing
- Reset values: `factor` = 0, `mask` = 0, `source_prev` = 0, `bus_data_out` = 0, `interrupt_req` = 0, `pending_valid` = 0, `pending_index` = 0.
- Source rises in cycle N:
  - The factor is set at the edge ending cycle N.
  - `interrupt_req` is visible in cycle N+1.
  - Event-to-request latency is 1 clock.
- Read strobe in cycle N: `bus_data_out` is valid in cycle N+1 and holds until the next read.
- Mask write in cycle N: the new mask affects `interrupt_req` in cycle N+1.
- Reset asserted mid-operation clears all state immediately. After release, a `source` already high counts as an event on the first edge.

## Test plan
- Reset, then line 0: reset with mask 0xF at 0x4, then pulse `source[0]` for 1 cycle -> `interrupt_req` = 15'h0001 one cycle later, `pending_index` = 0.
- Masked latch:
  - Mask 0, pulse `source[11]` -> `interrupt_req` stays 0.
  - Read of 0x2 is not performed.
  - Write 0x8 to addr 0x6 -> `interrupt_req` = 15'h0800 next cycle.
- Read-clear: with factor nibble 0 = 0x5, read 0x0 -> `bus_data_out` = 0x5 next cycle, then factor = 0 and `interrupt_req[3:0]` = 0.
- Set wins: `source[1]` rises in the same cycle as a read of 0x0 with factor = 0x1 -> read data 0x1, then factor = 0x2.
- Priority: lines 6 and 14 both pending and unmasked -> `pending_index` = 6 and addr 0x8 reads 0x6. Clear nibble 1 -> `pending_index` = 14 (0xE).
- Held level and reset: hold `source[3]` high for 10 cycles -> one event only. Assert reset mid-hold -> all outputs 0. Release reset -> factor bit 3 set again one cycle later.

Source files
------------

// File: rtl/interrupt_factor_ctrl.sv
// interrupt_factor_ctrl
// Latches rising edges of the peripheral interrupt sources into factor flags,
// gates them with a per-line mask and presents the result to the CPU core.
// Factor and mask nibbles are exposed on the 4-bit I/O bus. Reading a factor
// nibble clears it, but an event arriving on the same edge still sets its flag.
// The nibble packing assumes exactly 15 lines; line 15 (nibble 3, bit 3) is
// unimplemented and always reads 0.

module interrupt_factor_ctrl #(
  parameter int NUM_SOURCES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] source,
  input  logic [3:0]             bus_addr,
  input  logic                   bus_write_en,
  input  logic                   bus_read_en,
  input  logic [3:0]             bus_data_in,
  output logic [3:0]             bus_data_out,
  output logic [NUM_SOURCES-1:0] interrupt_req,
  output logic                   pending_valid,
  output logic [3:0]             pending_index
);

  logic [NUM_SOURCES-1:0] factor;
  logic [NUM_SOURCES-1:0] mask;
  logic [NUM_SOURCES-1:0] source_prev;
  logic [NUM_SOURCES-1:0] src_event;
  logic [NUM_SOURCES-1:0] clr_vec;
  logic [NUM_SOURCES-1:0] factor_next;
  logic [NUM_SOURCES-1:0] mask_next;
  logic [15:0]            factor_pad;
  logic [15:0]            mask_pad;
  logic [1:0]             nib;
  logic [3:0]             nib_base;
  logic                   factor_sel;
  logic                   mask_sel;
  logic [3:0]             rd_data;

  assign src_event  = source & ~source_prev;
  assign factor_pad = {1'b0, factor};
  assign mask_pad   = {1'b0, mask};
  assign nib        = bus_addr[1:0];
  assign nib_base   = {nib, 2'b00};
  assign factor_sel = (bus_addr[3:2] == 2'b00);
  assign mask_sel   = (bus_addr[3:2] == 2'b01);

  assign interrupt_req = factor & mask;
  assign pending_valid = |interrupt_req;

  // Factor update: read-clear of the addressed nibble, then new events win.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      clr_vec[i] = bus_read_en && factor_sel && (nib == 2'(i / 4));
    end
    factor_next = (factor & ~clr_vec) | src_event;
  end

  // Mask update: a write to a mask nibble replaces those four lines.
  always_comb begin
    mask_next = mask;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (bus_write_en && mask_sel && (nib == 2'(i / 4))) begin
        mask_next[i] = bus_data_in[i % 4];
      end
    end
  end

  // Priority encoder: scan from the lowest priority so line 0 ends up winning.
  always_comb begin
    pending_index = 4'd0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (interrupt_req[i]) begin
        pending_index = 4'(i);
      end
    end
  end

  // Read mux; the unimplemented bit 15 comes from the zero pad.
  always_comb begin
    rd_data = 4'h0;
    if (factor_sel) begin
      rd_data = factor_pad[nib_base +: 4];
    end else if (mask_sel) begin
      rd_data = mask_pad[nib_base +: 4];
    end else if (bus_addr == 4'h8) begin
      rd_data = pending_valid ? pending_index : 4'h0;
    end
  end

  // State registers; read data is captured only on a read strobe and then held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      factor       <= '0;
      mask         <= '0;
      source_prev  <= '0;
      bus_data_out <= 4'h0;
    end else begin
      source_prev <= source;
      factor      <= factor_next;
      mask        <= mask_next;
      if (bus_read_en) begin
        bus_data_out <= rd_data;
      end
    end
  end

endmodule
